// File: rtl/apu_reg_bank.sv
// apu_reg_bank: parametrised APU register file with decode, one-shot strobes, power gating and readback.
// Optional: define APU_LEN_WR_OFF_EN to keep register index 1 (length) writable, bits[5:0], while powered off.
module apu_reg_bank #(
    parameter int NUM_CH      = 4,
    parameter int REGS_PER_CH = 5,
    parameter int BASE_LO     = 8'h10,
    parameter int WAVE_BYTES  = 16
) (
    input  logic                              clk,
    input  logic                              nreset,
    input  logic [15:0]                       a,
    input  logic [7:0]                        d_in,
    input  logic                              cpu_wr,
    input  logic                              cpu_rd,
    input  logic [NUM_CH-1:0]                 ch_active,
    output logic [7:0]                        d_out,
    output logic                              d_oe,
    output logic [NUM_CH*REGS_PER_CH*8-1:0]   reg_q,
    output logic [NUM_CH*REGS_PER_CH-1:0]     wr_stb,
    output logic [NUM_CH-1:0]                 trig,
    output logic [7:0]                        vol_q,
    output logic [7:0]                        pan_q,
    output logic                              apu_on,
    output logic                              wave_we,
    output logic [$clog2(WAVE_BYTES)-1:0]     wave_addr
);
    localparam int NR   = NUM_CH * REGS_PER_CH;
    localparam int CTRL = BASE_LO + NR;
    localparam int WA   = $clog2(WAVE_BYTES);

    logic          hi;
    int            lo;
    logic [NR-1:0] sel;
    logic          vol_hit, pan_hit, pwr_hit, wave_hit, ch_hit;
    logic          wr_q, take;
    logic [7:0]    rd_val;

    assign hi       = a[15:8] == 8'hFF;
    assign lo       = {24'd0, a[7:0]};
    assign ch_hit   = |sel;
    assign vol_hit  = hi && lo == CTRL;
    assign pan_hit  = hi && lo == CTRL + 1;
    assign pwr_hit  = hi && lo == CTRL + 2;
    assign wave_hit = hi && lo >= 'h30 && lo < 'h30 + WAVE_BYTES;
    assign take     = cpu_wr && !wr_q;

    always_comb begin
        sel = '0;
        for (int i = 0; i < NR; i++) sel[i] = hi && lo == BASE_LO + i;
    end

    // Trigger bit of each channel's last register is write-only and reads back as 1.
    always_comb begin
        rd_val = 8'hFF;
        for (int i = 0; i < NR; i++)
            if (sel[i]) rd_val = reg_q[i*8 +: 8] | ((i % REGS_PER_CH == REGS_PER_CH - 1) ? 8'h80 : 8'h00);
        if (vol_hit) rd_val = vol_q;
        if (pan_hit) rd_val = pan_q;
        if (pwr_hit) rd_val = {apu_on, {(7 - NUM_CH){1'b1}}, ch_active & {NUM_CH{apu_on}}};
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wr_q      <= 1'b0;
            reg_q     <= '0;
            vol_q     <= 8'h00;
            pan_q     <= 8'h00;
            apu_on    <= 1'b0;
            wr_stb    <= '0;
            trig      <= '0;
            wave_we   <= 1'b0;
            wave_addr <= '0;
            d_out     <= 8'hFF;
            d_oe      <= 1'b0;
        end else begin
            wr_q    <= cpu_wr;
            wr_stb  <= '0;
            trig    <= '0;
            wave_we <= 1'b0;
            if (take && pwr_hit) begin
                apu_on <= d_in[7];
                if (!d_in[7]) begin
                    reg_q <= '0;
                    vol_q <= 8'h00;
                    pan_q <= 8'h00;
                end
            end
            if (take && apu_on) begin
                if (vol_hit) vol_q <= d_in;
                if (pan_hit) pan_q <= d_in;
                for (int i = 0; i < NR; i++)
                    if (sel[i]) begin
                        reg_q[i*8 +: 8] <= d_in;
                        wr_stb[i]       <= 1'b1;
                    end
                for (int c = 0; c < NUM_CH; c++)
                    if (sel[c*REGS_PER_CH + REGS_PER_CH - 1] && d_in[7]) trig[c] <= 1'b1;
            end
`ifdef APU_LEN_WR_OFF_EN
            if (take && !apu_on)
                for (int c = 0; c < NUM_CH; c++)
                    if (sel[c*REGS_PER_CH + 1]) begin
                        reg_q[(c*REGS_PER_CH + 1)*8 +: 6] <= d_in[5:0];
                        wr_stb[c*REGS_PER_CH + 1]         <= 1'b1;
                    end
`else
`endif
            if (take && wave_hit) begin
                wave_we   <= 1'b1;
                wave_addr <= a[WA-1:0];
            end
            if (cpu_rd) begin
                d_out <= rd_val;
                d_oe  <= ch_hit || vol_hit || pan_hit || pwr_hit;
            end else begin
                d_oe  <= 1'b0;
            end
        end
    end
endmodule
